brp_pht_ctrl: RTL
=================

BRP_PHT_CTRL -- requirements
Module: brp_pht_ctrl

Interface
REQ-001 Parameter: IDX_BITS, 6, log2 of pattern history table (PHT) entry count; table depth = 2**IDX_BITS.
REQ-002 Parameter: CNT_W, 16, width of the mispredict statistics counter.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: flush  in  1  single-cycle request to reinitialise the whole table.
REQ-006 Port: pred_req  in  1  fetch-stage prediction request.
REQ-007 Port: pred_pc  in  32  fetch PC for the prediction request.
REQ-008 Port: pred_valid  out  1  prediction result valid; registered.
REQ-009 Port: pred_taken  out  1  predicted direction; registered; 1 = taken.
REQ-010 Port: upd_valid  in  1  execute-stage branch resolution valid.
REQ-011 Port: upd_pc  in  32  PC of the resolved branch.
REQ-012 Port: upd_taken  in  1  actual branch outcome.
REQ-013 Port: upd_mispred  in  1  resolved branch was mispredicted.
REQ-014 Port: busy  out  1  high while the init sweep runs.
REQ-015 Port: mispred_cnt  out  CNT_W  saturating count of accepted mispredicted updates.

Function
REQ-016 Table: 2**IDX_BITS entries of 2-bit saturating counters in flops; 0 = strongly not-taken, 1 = weakly not-taken, 2 = weakly taken, 3 = strongly taken.
REQ-017 Index for any PC = pc[IDX_BITS+1:2]; pc[1:0] ignored.
REQ-018 FSM states: S_INIT (sweep), S_RUN (normal).
REQ-019 S_INIT: each cycle writes entry init_idx to 1 and increments init_idx; after writing the last entry (all ones), next state is S_RUN.
REQ-020 busy = 1 exactly when state is S_INIT; sweep takes 2**IDX_BITS cycles.
REQ-021 flush in S_RUN: next state S_INIT, init_idx = 0; flush in S_INIT: init_idx restarts at 0.
REQ-022 Prediction latency 1 cycle: pred_req at cycle N gives pred_valid = 1 at N+1; pred_valid = 0 at N+1 without pred_req at N.
REQ-023 In S_RUN, pred_taken = bit 1 of the indexed counter; in S_INIT (or on a flush cycle), pred_taken = 0 with pred_valid still asserted.
REQ-024 Update (S_RUN, upd_valid, no flush): indexed counter increments if upd_taken, else decrements; saturates at 3 and 0.
REQ-025 Same-cycle pred_req and update to the same index: prediction uses the post-update counter value (write-first bypass).
REQ-026 Updates during S_INIT or coincident with flush are dropped: table and mispred_cnt unchanged.
REQ-027 Accepted update with upd_mispred = 1 increments mispred_cnt; holds at 2**CNT_W-1; flush does not clear it.
REQ-028 pred_pc and upd_pc are ignored when the corresponding valid/req is low.

Reset
REQ-029 rst: state = S_INIT, init_idx = 0, pred_valid = 0, pred_taken = 0, mispred_cnt = 0; busy = 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-sweep or mid-operation overrides flush, pred_req and upd_valid, and restarts the sweep from 0.
REQ-031 Table contents need not be reset directly; the sweep defines them before S_RUN.

Verification
REQ-032 Reset, IDX_BITS = 6: busy high for exactly 64 cycles then low; pred_req for pc 0x100 in the first S_RUN cycle -> pred_valid = 1, pred_taken = 0 next cycle.
REQ-033 Saturation: two taken updates to pc 0x40 -> prediction taken; a third taken then one not-taken -> still taken (counter 2); four not-taken total -> counter 0, a further not-taken keeps it 0.
REQ-034 Bypass: counter at 1 for pc 0x80, same cycle upd_taken = 1 to 0x80 and pred_req 0x80 -> pred_taken = 1 next cycle; aliasing pc 0x180 (IDX_BITS = 6) shares the entry.
REQ-035 Flush: train pc 0x40 to 3, pulse flush -> busy high 64 cycles, an update during sweep is dropped, afterwards pc 0x40 predicts not-taken (counter 1).
REQ-036 Statistics: 3 accepted mispredicted updates plus 1 during S_INIT -> mispred_cnt = 3; with CNT_W = 2, 5 accepted mispredicts -> mispred_cnt = 3.
REQ-037 rst asserted at sweep cycle 30 -> sweep restarts, busy high for 64 more cycles after rst deasserts, mispred_cnt = 0.

Source files
------------

// File: rtl/brp_pht_ctrl.sv
// Branch direction predictor: 2-bit saturating-counter pattern history table
// with an init sweep after reset/flush and a saturating mispredict counter.
module brp_pht_ctrl #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             pred_req,
    input  logic [31:0]      pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    output logic             busy,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_BITS;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_BITS-1:0] r_init_idx;
    logic [IDX_BITS-1:0] w_init_idx_nxt;
    logic [1:0]          r_pht [DEPTH];
    logic                r_pred_valid;
    logic                r_pred_taken;
    logic [CNT_W-1:0]    r_mispred_cnt;

    logic [IDX_BITS-1:0] w_pred_idx;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic                w_upd_en;
    logic [1:0]          w_upd_cnt;
    logic [1:0]          w_upd_cnt_nxt;
    logic [1:0]          w_pred_cnt;
    logic                w_pred_taken_nxt;
    logic                w_unused;

    assign w_pred_idx = pred_pc[IDX_BITS+1:2];
    assign w_upd_idx  = upd_pc[IDX_BITS+1:2];
    assign w_unused   = &{1'b0, pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                          upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    assign w_upd_en  = (r_state == S_RUN) && upd_valid && !flush && !rst;
    assign w_upd_cnt = r_pht[w_upd_idx];

    always_comb begin
        w_upd_cnt_nxt = w_upd_cnt;
        if (upd_taken) begin
            if (w_upd_cnt != 2'd3)
                w_upd_cnt_nxt = w_upd_cnt + 2'd1;
        end else begin
            if (w_upd_cnt != 2'd0)
                w_upd_cnt_nxt = w_upd_cnt - 2'd1;
        end
    end

    // Write-first bypass: a same-cycle update to the predicted entry wins.
    assign w_pred_cnt = (w_upd_en && (w_upd_idx == w_pred_idx)) ?
                        w_upd_cnt_nxt : r_pht[w_pred_idx];

    assign w_pred_taken_nxt = (r_state == S_RUN) && !flush &&
                              pred_req && w_pred_cnt[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        unique case (r_state)
            S_INIT: begin
                if (flush) begin
                    w_init_idx_nxt = '0;
                end else begin
                    w_init_idx_nxt = r_init_idx + IDX_BITS'(1);
                    if (&r_init_idx)
                        w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt    = S_INIT;
                    w_init_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_INIT;
                w_init_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    // Table has no reset; the sweep defines every entry before S_RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT)
                r_pht[r_init_idx] <= 2'd1;
            else if (w_upd_en)
                r_pht[w_upd_idx] <= w_upd_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= pred_req;
            r_pred_taken <= w_pred_taken_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_mispred_cnt <= '0;
        else if (w_upd_en && upd_mispred && (r_mispred_cnt != '1))
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign busy        = (r_state == S_INIT);
    assign mispred_cnt = r_mispred_cnt;

endmodule
